// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the CPU/external memory arbiter: owners, FSM states, access sizes,
// and the data returned to the owner when a memory access is aborted.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_IR  = 2'd0,
        OWN_DR  = 2'd1,
        OWN_DW  = 2'd2,
        OWN_EXT = 2'd3
    } owner_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [1:0]  SIZE_BYTE    = 2'b00;
    localparam logic [1:0]  SIZE_HALF    = 2'b01;
    localparam logic [1:0]  SIZE_WORD    = 2'b10;
    localparam logic [31:0] TIMEOUT_FILL = 32'hDEAD_BEEF;

    // Word wins when both size strobes are set.
    function automatic logic [1:0] size_enc(input logic w, input logic hw);
        if (w) return SIZE_WORD;
        if (hw) return SIZE_HALF;
        return SIZE_BYTE;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the CPU request bus, the external loader port and the memory controller.
// slave = arbiter view, master = environment (CPU, loader and memory) view.
interface mem_bus_arbiter_if;
    logic        i_read_req;
    logic        i_read_w;
    logic        i_read_hw;
    logic [31:0] i_read_adr;
    logic        d_read_req;
    logic        d_read_w;
    logic        d_read_hw;
    logic [31:0] d_read_adr;
    logic        d_write_req;
    logic        d_write_w;
    logic        d_write_hw;
    logic [31:0] d_write_adr;
    logic [31:0] d_write_data;
    logic        read_valid;
    logic [31:0] read_data;
    logic        write_finish;
    logic        ext_req;
    logic        ext_we;
    logic [31:0] ext_adr;
    logic [31:0] ext_wdata;
    logic        ext_ack;
    logic [31:0] ext_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_adr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        bus_err;

    modport slave (
        input  i_read_req, i_read_w, i_read_hw, i_read_adr,
        input  d_read_req, d_read_w, d_read_hw, d_read_adr,
        input  d_write_req, d_write_w, d_write_hw, d_write_adr, d_write_data,
        output read_valid, read_data, write_finish,
        input  ext_req, ext_we, ext_adr, ext_wdata,
        output ext_ack, ext_rdata,
        output mem_req, mem_we, mem_size, mem_adr, mem_wdata,
        input  mem_ack, mem_rdata,
        output bus_err
    );

    modport master (
        output i_read_req, i_read_w, i_read_hw, i_read_adr,
        output d_read_req, d_read_w, d_read_hw, d_read_adr,
        output d_write_req, d_write_w, d_write_hw, d_write_adr, d_write_data,
        input  read_valid, read_data, write_finish,
        output ext_req, ext_we, ext_adr, ext_wdata,
        input  ext_ack, ext_rdata,
        input  mem_req, mem_we, mem_size, mem_adr, mem_wdata,
        output mem_ack, mem_rdata,
        input  bus_err
    );
endinterface

// File: rtl/mem_arb_rr.sv
// Two-way round-robin grant between the CPU side and the external port.
// On a tie the side that did not win last time is granted.
module mem_arb_rr (
    input  logic i_cpu_any,
    input  logic i_ext_req,
    input  logic i_last_ext,
    output logic o_grant_cpu,
    output logic o_grant_ext
);
    assign o_grant_cpu = i_cpu_any && (!i_ext_req || i_last_ext);
    assign o_grant_ext = i_ext_req && (!i_cpu_any || !i_last_ext);
endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-ported memory arbiter between CPU (ifetch/load/store) and external loader, one access at a time.
// Define MEM_TIMEOUT_EN to abort accesses that see no mem_ack within TIMEOUT_CYC cycles (sticky bus_err).
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input logic              clk,
    input logic              rst_n,
    mem_bus_arbiter_if.slave bus
);
    state_t      r_state;
    owner_t      r_owner;
    logic        r_last_ext;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [1:0]  r_mem_size;
    logic [31:0] r_mem_adr;
    logic [31:0] r_mem_wdata;
    logic        r_read_valid;
    logic [31:0] r_read_data;
    logic        r_write_finish;
    logic        r_ext_ack;
    logic [31:0] r_ext_rdata;

    logic        w_cpu_any;
    logic        w_grant_cpu;
    logic        w_grant_ext;
    logic        w_timeout;
    logic [31:0] w_resp_data;
    owner_t      w_cpu_owner;
    logic        w_cpu_we;
    logic [1:0]  w_cpu_size;
    logic [31:0] w_cpu_adr;
    logic [31:0] w_cpu_wdata;

    assign w_cpu_any = bus.d_write_req || bus.d_read_req || bus.i_read_req;

    // CPU issues one request at a time; fixed order only matters if it ever breaks that rule.
    always_comb begin
        w_cpu_owner = OWN_IR;
        w_cpu_we    = 1'b0;
        w_cpu_size  = size_enc(bus.i_read_w, bus.i_read_hw);
        w_cpu_adr   = bus.i_read_adr;
        w_cpu_wdata = '0;
        if (bus.d_write_req) begin
            w_cpu_owner = OWN_DW;
            w_cpu_we    = 1'b1;
            w_cpu_size  = size_enc(bus.d_write_w, bus.d_write_hw);
            w_cpu_adr   = bus.d_write_adr;
            w_cpu_wdata = bus.d_write_data;
        end else if (bus.d_read_req) begin
            w_cpu_owner = OWN_DR;
            w_cpu_size  = size_enc(bus.d_read_w, bus.d_read_hw);
            w_cpu_adr   = bus.d_read_adr;
        end
    end

    mem_arb_rr u_rr (
        .i_cpu_any  (w_cpu_any),
        .i_ext_req  (bus.ext_req),
        .i_last_ext (r_last_ext),
        .o_grant_cpu(w_grant_cpu),
        .o_grant_ext(w_grant_ext)
    );

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT_CYC - 1);

    logic [7:0] r_tmo_cnt;
    logic       r_bus_err;

    // Down-counter loaded at grant; reaching zero while still BUSY means the memory never answered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
            r_bus_err <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && (w_grant_cpu || w_grant_ext))
                r_tmo_cnt <= TMO_LOAD;
            else if (r_state == ST_BUSY && r_tmo_cnt != 8'd0)
                r_tmo_cnt <= r_tmo_cnt - 8'd1;
            if (w_timeout)
                r_bus_err <= 1'b1;
        end
    end

    assign w_timeout   = (r_state == ST_BUSY) && !bus.mem_ack && (r_tmo_cnt == 8'd0);
    assign bus.bus_err = r_bus_err;
`else
    assign w_timeout   = 1'b0;
    assign bus.bus_err = 1'b0;
`endif

    assign w_resp_data = bus.mem_ack ? bus.mem_rdata : TIMEOUT_FILL;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_owner        <= OWN_IR;
            r_last_ext     <= 1'b1;
            r_mem_req      <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_size     <= '0;
            r_mem_adr      <= '0;
            r_mem_wdata    <= '0;
            r_read_valid   <= 1'b0;
            r_read_data    <= '0;
            r_write_finish <= 1'b0;
            r_ext_ack      <= 1'b0;
            r_ext_rdata    <= '0;
        end else begin
            r_read_valid   <= 1'b0;
            r_write_finish <= 1'b0;
            r_ext_ack      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_cpu || w_grant_ext) begin
                        r_last_ext <= w_grant_ext;
                        r_mem_req  <= 1'b1;
                        r_state    <= ST_BUSY;
                        if (w_grant_ext) begin
                            r_owner     <= OWN_EXT;
                            r_mem_we    <= bus.ext_we;
                            r_mem_size  <= SIZE_WORD;
                            r_mem_adr   <= bus.ext_adr;
                            r_mem_wdata <= bus.ext_wdata;
                        end else begin
                            r_owner     <= w_cpu_owner;
                            r_mem_we    <= w_cpu_we;
                            r_mem_size  <= w_cpu_size;
                            r_mem_adr   <= w_cpu_adr;
                            r_mem_wdata <= w_cpu_wdata;
                        end
                    end
                end
                ST_BUSY: begin
                    if (bus.mem_ack || w_timeout) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ST_RESP;
                        case (r_owner)
                            OWN_IR, OWN_DR: begin
                                r_read_valid <= 1'b1;
                                r_read_data  <= w_resp_data;
                            end
                            OWN_DW: r_write_finish <= 1'b1;
                            default: begin
                                r_ext_ack <= 1'b1;
                                if (!r_mem_we)
                                    r_ext_rdata <= w_resp_data;
                            end
                        endcase
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_req      = r_mem_req;
    assign bus.mem_we       = r_mem_we;
    assign bus.mem_size     = r_mem_size;
    assign bus.mem_adr      = r_mem_adr;
    assign bus.mem_wdata    = r_mem_wdata;
    assign bus.read_valid   = r_read_valid;
    assign bus.read_data    = r_read_data;
    assign bus.write_finish = r_write_finish;
    assign bus.ext_ack      = r_ext_ack;
    assign bus.ext_rdata    = r_ext_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: drivers push expected memory accesses and responses,
// a negedge monitor pops and compares them; a memory model answers with random latency.
module tb_mem_bus_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_bus_arbiter_if bus();

    mem_bus_arbiter #(.TIMEOUT_CYC(255)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic [31:0] adr;
        logic [31:0] wdata;
    } mreq_t;

    typedef struct {
        logic        is_wr;
        logic [31:0] data;
    } rsp_t;

    mreq_t       cpu_mq[$];
    mreq_t       ext_mq[$];
    rsp_t        cpu_rq[$];
    rsp_t        ext_rq[$];
    logic [31:0] mem_ovr[logic [31:0]];

    int          n_tests  = 0;
    int          n_fail   = 0;
    bit          mem_mute = 1'b0;
    bit          skip_lat = 1'b0;
    int          ack_dly  = -1;
    logic [31:0] exp_read_data = '0;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return {a[15:0] ^ 16'h5A3C, ~a[31:16]};
    endfunction

    function automatic logic [1:0] exp_size(input logic w, input logic hw);
        return w ? 2'b10 : (hw ? 2'b01 : 2'b00);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event missing or unexpected at %0t", nm, $time);
    endtask

    task automatic chk_m(input string pfx, input mreq_t m);
        chk({pfx, "_mem_we"}, bus.mem_we, m.we);
        chk({pfx, "_mem_size"}, bus.mem_size, m.size);
        chk({pfx, "_mem_adr"}, bus.mem_adr, m.adr);
        if (m.we) chk({pfx, "_mem_wdata"}, bus.mem_wdata, m.wdata);
    endtask

    // Memory model: acks each access after 0..3 cycles, sometimes acks spuriously while idle.
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.mem_req && !mem_mute) begin
                int d;
                d = (ack_dly >= 0) ? ack_dly : $urandom_range(0, 3);
                repeat (d) begin @(posedge clk); #1; end
                if (bus.mem_req && !mem_mute) begin
                    bus.mem_rdata = mem_val(bus.mem_adr);
                    bus.mem_ack   = 1'b1;
                    @(posedge clk); #1;
                    bus.mem_ack   = 1'b0;
                    bus.mem_rdata = $urandom;
                end
            end else if (!bus.mem_req && rst_n && $urandom_range(0, 7) == 0) begin
                bus.mem_rdata = $urandom;
                bus.mem_ack   = 1'b1;
                @(posedge clk); #1;
                bus.mem_ack   = 1'b0;
            end
        end
    end

    // Monitor: response pulses, response data, and grant order / memory fields.
    logic prev_ack_req = 1'b0, prev_mreq = 1'b0, prev_cpu = 1'b0, prev_ext = 1'b0, last_ext = 1'b1;
    always @(negedge clk) begin
        int    np;
        rsp_t  r;
        mreq_t m;
        logic  win_ext;
        if (!rst_n) begin
            prev_ack_req  = 1'b0;
            prev_mreq     = 1'b0;
            prev_cpu      = 1'b0;
            prev_ext      = 1'b0;
            last_ext      = 1'b1;
            exp_read_data = '0;
        end else begin
            np = int'(bus.read_valid) + int'(bus.write_finish) + int'(bus.ext_ack);
            if (!skip_lat && (prev_ack_req || np != 0))
                chk("resp_pulse_after_ack", np, prev_ack_req ? 1 : 0);
            if (bus.read_valid) begin
                if (cpu_rq.size() == 0) fail("cpu_read_unexpected");
                else begin
                    r = cpu_rq.pop_front();
                    chk("cpu_rsp_is_read", r.is_wr, 1'b0);
                    chk("read_data", bus.read_data, r.data);
                    exp_read_data = r.data;
                end
            end
            if (bus.write_finish) begin
                if (cpu_rq.size() == 0) fail("cpu_write_unexpected");
                else begin
                    r = cpu_rq.pop_front();
                    chk("cpu_rsp_is_write", r.is_wr, 1'b1);
                end
            end
            if (bus.ext_ack) begin
                if (ext_rq.size() == 0) fail("ext_ack_unexpected");
                else begin
                    r = ext_rq.pop_front();
                    if (!r.is_wr) chk("ext_rdata", bus.ext_rdata, r.data);
                    chk("read_data_kept_on_ext", bus.read_data, exp_read_data);
                end
            end
            if (bus.mem_req && !prev_mreq) begin
                if (!prev_cpu && !prev_ext) fail("grant_without_request");
                win_ext  = (prev_cpu && prev_ext) ? !last_ext : prev_ext;
                last_ext = win_ext;
                if (win_ext) begin
                    if (ext_mq.size() == 0) fail("ext_grant_unexpected");
                    else begin m = ext_mq.pop_front(); chk_m("ext", m); end
                end else begin
                    if (cpu_mq.size() == 0) fail("cpu_grant_unexpected");
                    else begin m = cpu_mq.pop_front(); chk_m("cpu", m); end
                end
            end
            prev_ack_req = bus.mem_ack && bus.mem_req;
            prev_mreq    = bus.mem_req;
            prev_cpu     = bus.i_read_req || bus.d_read_req || bus.d_write_req;
            prev_ext     = bus.ext_req;
        end
    end

    // kind: 0 ifetch, 1 load, 2 store. Called and returns at posedge+1.
    task automatic cpu_op(input int kind, input logic [31:0] adr, input logic w, input logic hw,
                          input logic [31:0] wd);
        mreq_t m;
        rsp_t  r;
        bit    done;
        case (kind)
            0: begin bus.i_read_adr = adr; bus.i_read_w = w; bus.i_read_hw = hw; bus.i_read_req = 1'b1; end
            1: begin bus.d_read_adr = adr; bus.d_read_w = w; bus.d_read_hw = hw; bus.d_read_req = 1'b1; end
            default: begin
                bus.d_write_adr = adr; bus.d_write_w = w; bus.d_write_hw = hw;
                bus.d_write_data = wd; bus.d_write_req = 1'b1;
            end
        endcase
        m.we = (kind == 2); m.size = exp_size(w, hw); m.adr = adr; m.wdata = wd;
        r.is_wr = (kind == 2);
        r.data  = (kind == 2) ? 32'h0 : mem_val(adr);
        cpu_mq.push_back(m);
        cpu_rq.push_back(r);
        done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clk);
            done = (kind == 2) ? bus.write_finish : bus.read_valid;
        end
        if (!done) fail("cpu_op_no_response");
        @(posedge clk); #1;
        bus.i_read_req = 1'b0; bus.d_read_req = 1'b0; bus.d_write_req = 1'b0;
    endtask

    task automatic ext_op(input logic we, input logic [31:0] adr, input logic [31:0] wd);
        mreq_t m;
        rsp_t  r;
        bit    done;
        bus.ext_we = we; bus.ext_adr = adr; bus.ext_wdata = wd; bus.ext_req = 1'b1;
        m.we = we; m.size = 2'b10; m.adr = adr; m.wdata = wd;
        r.is_wr = we;
        r.data  = we ? 32'h0 : mem_val(adr);
        ext_mq.push_back(m);
        ext_rq.push_back(r);
        done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clk);
            done = bus.ext_ack;
        end
        if (!done) fail("ext_op_no_response");
        @(posedge clk); #1;
        bus.ext_req = 1'b0;
    endtask

    task automatic cpu_rand(input int n);
        for (int i = 0; i < n; i++) begin
            int g = $urandom_range(0, 3);
            repeat (g) begin @(posedge clk); #1; end
            cpu_op($urandom_range(0, 2), $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
        end
    endtask

    task automatic ext_rand(input int n);
        for (int i = 0; i < n; i++) begin
            int g = $urandom_range(0, 4);
            repeat (g) begin @(posedge clk); #1; end
            ext_op(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom);
        end
    endtask

    initial begin
        bus.i_read_req = 1'b0; bus.i_read_w = 1'b0; bus.i_read_hw = 1'b0; bus.i_read_adr = '0;
        bus.d_read_req = 1'b0; bus.d_read_w = 1'b0; bus.d_read_hw = 1'b0; bus.d_read_adr = '0;
        bus.d_write_req = 1'b0; bus.d_write_w = 1'b0; bus.d_write_hw = 1'b0; bus.d_write_adr = '0;
        bus.d_write_data = '0;
        bus.ext_req = 1'b0; bus.ext_we = 1'b0; bus.ext_adr = '0; bus.ext_wdata = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_mem_adr", bus.mem_adr, 32'h0);
        chk("rst_read_valid", bus.read_valid, 1'b0);
        chk("rst_write_finish", bus.write_finish, 1'b0);
        chk("rst_ext_ack", bus.ext_ack, 1'b0);
        chk("rst_read_data", bus.read_data, 32'h0);
        chk("rst_ext_rdata", bus.ext_rdata, 32'h0);
        chk("rst_bus_err", bus.bus_err, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Simultaneous CPU and external requests right after reset: CPU first, then alternating.
        fork
            begin for (int i = 0; i < 3; i++) cpu_op(0, 32'h1000 + 32'(i * 4), 1'b1, 1'b0, 32'h0); end
            begin for (int i = 0; i < 3; i++) ext_op(1'b0, 32'h2000 + 32'(i * 4), 32'h0); end
        join

        ack_dly = 2;
        mem_ovr[32'h100] = 32'h0000_0013;
        cpu_op(0, 32'h100, 1'b1, 1'b0, 32'h0);
        ack_dly = -1;
        cpu_op(2, 32'h204, 1'b0, 1'b1, 32'h1234);
        mem_ovr[32'h40] = 32'hCAFE_0000;
        ext_op(1'b0, 32'h40, 32'h0);
        chk("read_data_after_ext_read", bus.read_data, 32'h0000_0013);

        fork
            cpu_rand(40);
            ext_rand(40);
        join

        // Reset while BUSY: outputs drop immediately, then a fresh request is served normally.
        begin : rst_mid_blk
            mreq_t m;
            bit    up;
            mem_mute = 1'b1;
            bus.i_read_adr = 32'h300; bus.i_read_w = 1'b1; bus.i_read_hw = 1'b0; bus.i_read_req = 1'b1;
            m.we = 1'b0; m.size = 2'b10; m.adr = 32'h300; m.wdata = '0;
            cpu_mq.push_back(m);
            up = 1'b0;
            for (int i = 0; i < 20 && !up; i++) begin @(negedge clk); up = bus.mem_req; end
            if (!up) fail("rst_mid_no_mem_req");
            @(posedge clk); #3;
            rst_n = 1'b0;
            #1;
            chk("rst_mid_mem_req", bus.mem_req, 1'b0);
            chk("rst_mid_read_valid", bus.read_valid, 1'b0);
            chk("rst_mid_read_data", bus.read_data, 32'h0);
            bus.i_read_req = 1'b0;
            cpu_mq.delete(); cpu_rq.delete(); ext_mq.delete(); ext_rq.delete();
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            mem_mute = 1'b0;
            @(posedge clk); #1;
            cpu_op(1, 32'h308, 1'b0, 1'b0, 32'h0);
        end

`ifdef MEM_TIMEOUT_EN
        begin : tmo_blk
            mreq_t m;
            rsp_t  r;
            int    hi;
            bit    got;
            mem_mute = 1'b1; skip_lat = 1'b1; hi = 0; got = 1'b0;
            bus.i_read_adr = 32'h500; bus.i_read_w = 1'b1; bus.i_read_hw = 1'b0; bus.i_read_req = 1'b1;
            m.we = 1'b0; m.size = 2'b10; m.adr = 32'h500; m.wdata = '0;
            r.is_wr = 1'b0; r.data = 32'hDEAD_BEEF;
            cpu_mq.push_back(m);
            cpu_rq.push_back(r);
            for (int i = 0; i < 400 && !got; i++) begin
                @(negedge clk);
                if (bus.mem_req) hi++;
                got = bus.read_valid;
            end
            if (!got) fail("timeout_no_response");
            chk("timeout_busy_cycles", hi, 255);
            chk("bus_err_set", bus.bus_err, 1'b1);
            @(posedge clk); #1;
            bus.i_read_req = 1'b0; mem_mute = 1'b0; skip_lat = 1'b0;
            cpu_op(0, 32'h504, 1'b1, 1'b0, 32'h0);
            chk("bus_err_sticky", bus.bus_err, 1'b1);
        end
`else
        chk("bus_err_tied_low", bus.bus_err, 1'b0);
`endif

        repeat (5) @(posedge clk);
        #1;
        chk("queues_drained", cpu_mq.size() + cpu_rq.size() + ext_mq.size() + ext_rq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
